// File: rtl/apu_mix_sched_if.sv
// Bundles for apu_mix_sched: system clock/reset and the
// sample output valid/ready handshake.
interface sys_if;
    logic clk;
    logic n_reset;

    modport master (output clk, output n_reset);
    modport slave  (input  clk, input  n_reset);
endinterface

interface apu_mix_sched_if;
    logic [7:0] out_sample;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_sample, output out_valid, input  out_ready);
    modport slave  (input  out_sample, input  out_valid, output out_ready);
endinterface

// File: rtl/apu_mix_sched.sv
// APU mixer sequencer: time-shares one synchronous lookup ROM between
// the pulse and TND tables and emits the saturated 8-bit sum.
module apu_mix_sched #(
    parameter int TND_BASE = 32,
    parameter int OVR_W    = 8
) (
    sys_if.slave             sys,
    input  logic             i_tick,
    input  logic [1:0][3:0]  i_pulse,
    input  logic [3:0]       i_triangle,
    input  logic [3:0]       i_noise,
    input  logic [6:0]       i_dmc,
    output logic [7:0]       o_rom_addr,
    output logic             o_rom_en,
    input  logic [7:0]       i_rom_q,
    apu_mix_sched_if.master  smp,
    output logic [OVR_W-1:0] o_ovr_count,
    input  logic             i_ovr_clr,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_P,
        S_ADDR_T,
        S_CAP_T,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_pending;
    logic [1:0][3:0]  r_pulse;
    logic [3:0]       r_triangle;
    logic [3:0]       r_noise;
    logic [6:0]       r_dmc;
    logic [6:0]       r_pulse_val;
    logic [7:0]       r_sample;
    logic             r_valid;
    logic [OVR_W-1:0] r_ovr;
    logic [7:0]       r_rom_addr;
    logic             r_rom_en;

    logic             w_hs;
    logic             w_start;
    logic             w_busy_tick;
    logic [4:0]       w_p_addr;
    logic [7:0]       w_t_addr;
    logic [8:0]       w_sum;

    assign w_hs        = r_valid & smp.out_ready;
    assign w_start     = ((r_state == S_IDLE) & i_tick)
                       | ((r_state == S_OUT) & w_hs & (r_pending | i_tick));
    assign w_busy_tick = i_tick & (r_state != S_IDLE) & ~w_start;

    // Pulse address comes from live inputs: it is registered on the start edge.
    assign w_p_addr = {1'b0, i_pulse[0]} + {1'b0, i_pulse[1]};
    assign w_t_addr = 8'(TND_BASE)
                    + 8'({r_triangle, 1'b0}) + 8'(r_triangle)
                    + 8'({r_noise, 1'b0}) + 8'(r_dmc);
    assign w_sum    = {2'b00, r_pulse_val} + {1'b0, i_rom_q};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_tick) w_next = S_ADDR_P;
            S_ADDR_P: w_next = S_ADDR_T;
            S_ADDR_T: w_next = S_CAP_T;
            S_CAP_T:  w_next = S_OUT;
            S_OUT:    if (w_hs) w_next = w_start ? S_ADDR_P : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys.clk or negedge sys.n_reset) begin
        if (!sys.n_reset) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_pulse     <= '0;
            r_triangle  <= '0;
            r_noise     <= '0;
            r_dmc       <= '0;
            r_pulse_val <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_ovr       <= '0;
            r_rom_addr  <= '0;
            r_rom_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_pulse    <= i_pulse;
                r_triangle <= i_triangle;
                r_noise    <= i_noise;
                r_dmc      <= i_dmc;
                r_pending  <= 1'b0;
                r_rom_en   <= 1'b1;
                r_rom_addr <= {3'b000, w_p_addr};
            end else if (w_busy_tick) begin
                r_pending <= 1'b1;
            end
            if (r_state == S_ADDR_P) r_rom_addr <= w_t_addr;
            if (r_state == S_ADDR_T) begin
                r_rom_en    <= 1'b0;
                r_pulse_val <= i_rom_q[6:0];
            end
            if (r_state == S_CAP_T) begin
                r_sample <= w_sum[8] ? 8'hFF : w_sum[7:0];
                r_valid  <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            // Clear beats a coincident overrun.
            if (i_ovr_clr) r_ovr <= '0;
            else if (w_busy_tick && r_pending && !(&r_ovr)) r_ovr <= r_ovr + 1'b1;
        end
    end

    assign o_rom_addr     = r_rom_addr;
    assign o_rom_en       = r_rom_en;
    assign smp.out_sample = r_sample;
    assign smp.out_valid  = r_valid;
    assign o_ovr_count    = r_ovr;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_apu_mix_sched.sv
// Self-checking bench for apu_mix_sched: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_apu_mix_sched;

    localparam int TND = 32;

    sys_if           sys ();
    apu_mix_sched_if smp ();

    logic            tick;
    logic [1:0][3:0] pulse;
    logic [3:0]      triangle;
    logic [3:0]      noise;
    logic [6:0]      dmc;
    logic [7:0]      rom_addr;
    logic            rom_en;
    logic [7:0]      rom_q;
    logic [7:0]      ovr_count;
    logic            ovr_clr;
    logic            busy;

    logic [7:0] rom_tab [256];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: age = edges since the start edge (0 = idle, 4 = sample offered)
    int         m_age;
    bit         m_pend;
    int         m_ovr;
    int         m_pa;
    int         m_ta;
    logic [7:0] m_cur;
    logic [7:0] m_out;
    int         m_rom_addr;

    apu_mix_sched #(.TND_BASE(TND), .OVR_W(8)) dut (
        .sys        (sys),
        .i_tick     (tick),
        .i_pulse    (pulse),
        .i_triangle (triangle),
        .i_noise    (noise),
        .i_dmc      (dmc),
        .o_rom_addr (rom_addr),
        .o_rom_en   (rom_en),
        .i_rom_q    (rom_q),
        .smp        (smp),
        .o_ovr_count(ovr_count),
        .i_ovr_clr  (ovr_clr),
        .o_busy     (busy)
    );

    initial begin
        sys.clk = 1'b0;
        forever #5 sys.clk = ~sys.clk;
    end

    initial rom_q = 8'h00;
    always @(posedge sys.clk) if (rom_en) rom_q <= rom_tab[rom_addr];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int paddr(logic [3:0] a, logic [3:0] b);
        return int'(a) + int'(b);
    endfunction

    function automatic int taddr(logic [3:0] t, logic [3:0] n, logic [6:0] d);
        return TND + 3 * int'(t) + 2 * int'(n) + int'(d);
    endfunction

    function automatic logic [7:0] exp_sample(int pa, int ta);
        logic [7:0] p;
        int s;
        p = rom_tab[pa];
        s = int'(p[6:0]) + int'(rom_tab[ta]);
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    task automatic model_reset();
        m_age = 0; m_pend = 0; m_ovr = 0;
        m_pa = 0; m_ta = 0; m_cur = 0; m_out = 0; m_rom_addr = 0;
    endtask

    task automatic fill_rom(int mode);
        for (int a = 0; a < 256; a++) begin
            if (mode == 0) rom_tab[a] = 8'(a) ^ 8'h5A;
            else if (mode == 1) rom_tab[a] = 8'(a);
            else rom_tab[a] = 8'($urandom_range(0, 255));
        end
    endtask

    // one clock edge: model predicts from the inputs the DUT samples
    task automatic step();
        bit hs, st;
        int na;
        hs = (m_age == 4) && smp.out_ready;
        st = (m_age == 0 && tick) || (hs && (m_pend || tick));
        if (st) begin
            m_pa  = paddr(pulse[0], pulse[1]);
            m_ta  = taddr(triangle, noise, dmc);
            m_cur = exp_sample(m_pa, m_ta);
        end
        if (st) na = 1;
        else if (m_age == 0) na = 0;
        else if (m_age < 4) na = m_age + 1;
        else na = hs ? 0 : 4;
        if (st) m_pend = 0;
        else if (tick && m_age != 0) begin
            if (!m_pend) m_pend = 1;
            else if (m_ovr < 255) m_ovr++;
        end
        if (ovr_clr) m_ovr = 0;
        @(posedge sys.clk);
        #1;
        if (st) m_rom_addr = m_pa;
        else if (m_age == 1) m_rom_addr = m_ta;
        if (m_age == 3) m_out = m_cur;
        m_age = na;
    endtask

    task automatic set_in(int p0, int p1, int t, int n, int d);
        pulse[0] = 4'(p0); pulse[1] = 4'(p1);
        triangle = 4'(t); noise = 4'(n); dmc = 7'(d);
    endtask

    task automatic test_reset();
        sys.n_reset = 1'b0;
        tick = 0; ovr_clr = 0; smp.out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #12;
        n_checks++;
        if ({smp.out_valid, rom_en, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctl: valid/en/busy=%b want 000", {smp.out_valid, rom_en, busy});
        end
        n_checks++;
        if (smp.out_sample !== 8'h00 || rom_addr !== 8'h00 || ovr_count !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_data: sample=%h addr=%h ovr=%h want 00",
                     smp.out_sample, rom_addr, ovr_count);
        end
        #11 sys.n_reset = 1'b1;
        @(posedge sys.clk);
        #1;
    endtask

    task automatic test_zero();
        fill_rom(0);
        set_in(0, 0, 0, 0, 0);
        tick = 1; step(); tick = 0;
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_paddr: en=%b addr=%0d want 1/0", rom_en, rom_addr);
        end
        step();
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 8'd32) begin
            n_errors++;
            $display("FAIL zero_taddr: en=%b addr=%0d want 1/32", rom_en, rom_addr);
        end
        step();
        n_checks++;
        if (rom_en !== 1'b0 || smp.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_cap: en=%b valid=%b want 0/0", rom_en, smp.out_valid);
        end
        step();
        n_checks++;
        if (smp.out_valid !== 1'b1 || smp.out_sample !== 8'hD4) begin
            n_errors++;
            $display("FAIL zero_out: valid=%b sample=%h want 1/d4", smp.out_valid, smp.out_sample);
        end
        step();
        n_checks++;
        if (smp.out_valid !== 1'b0 || busy !== 1'b0 || smp.out_sample !== 8'hD4) begin
            n_errors++;
            $display("FAIL zero_done: valid=%b busy=%b sample=%h want 0/0/d4",
                     smp.out_valid, busy, smp.out_sample);
        end
    endtask

    task automatic test_max();
        fill_rom(1);
        set_in(15, 15, 15, 15, 127);
        tick = 1; step(); tick = 0;
        set_in(0, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 8'd30) begin
            n_errors++;
            $display("FAIL max_paddr: addr=%0d want 30", rom_addr);
        end
        step();
        n_checks++;
        if (rom_addr !== 8'd234) begin
            n_errors++;
            $display("FAIL max_taddr: addr=%0d want 234", rom_addr);
        end
        step(); step();
        n_checks++;
        if (smp.out_valid !== 1'b1 || smp.out_sample !== 8'hFF) begin
            n_errors++;
            $display("FAIL max_sat: valid=%b sample=%h want 1/ff", smp.out_valid, smp.out_sample);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        fill_rom(2);
        smp.out_ready = 1'b0;
        set_in(3, 9, 7, 2, 55);
        tick = 1; step(); tick = 0;
        step(); step(); step();
        held = exp_sample(12, TND + 21 + 4 + 55);
        for (int i = 0; i < 10; i++) begin
            set_in($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 127));
            n_checks++;
            if (smp.out_valid !== 1'b1 || smp.out_sample !== held) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: valid=%b sample=%h want 1/%h",
                         i, smp.out_valid, smp.out_sample, held);
            end
            step();
        end
        smp.out_ready = 1'b1;
        step();
        n_checks++;
        if (smp.out_valid !== 1'b0 || busy !== 1'b0 || smp.out_sample !== held) begin
            n_errors++;
            $display("FAIL bp_accept: valid=%b busy=%b sample=%h want 0/0/%h",
                     smp.out_valid, busy, smp.out_sample, held);
        end
    endtask

    task automatic test_overload();
        logic [7:0] ea, eb;
        fill_rom(2);
        smp.out_ready = 1'b1;
        set_in(1, 2, 3, 4, 5);
        ea = exp_sample(3, taddr(3, 4, 5));
        eb = exp_sample(17, taddr(9, 1, 100));
        tick = 1;
        step(); step();
        n_checks++;
        if (ovr_count !== 8'd0) begin
            n_errors++;
            $display("FAIL ovl_pending: ovr=%0d want 0", ovr_count);
        end
        step(); step();
        tick = 0;
        n_checks++;
        if (ovr_count !== 8'd2 || smp.out_valid !== 1'b1 || smp.out_sample !== ea) begin
            n_errors++;
            $display("FAIL ovl_first: ovr=%0d valid=%b sample=%h want 2/1/%h",
                     ovr_count, smp.out_valid, smp.out_sample, ea);
        end
        set_in(8, 9, 9, 1, 100);
        step();
        n_checks++;
        if (busy !== 1'b1 || smp.out_valid !== 1'b0 || rom_addr !== 8'd17) begin
            n_errors++;
            $display("FAIL ovl_restart: busy=%b valid=%b addr=%0d want 1/0/17",
                     busy, smp.out_valid, rom_addr);
        end
        step(); step(); step();
        n_checks++;
        if (smp.out_valid !== 1'b1 || smp.out_sample !== eb) begin
            n_errors++;
            $display("FAIL ovl_second: valid=%b sample=%h want 1/%h",
                     smp.out_valid, smp.out_sample, eb);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || ovr_count !== 8'd2) begin
            n_errors++;
            $display("FAIL ovl_idle: busy=%b ovr=%0d want 0/2", busy, ovr_count);
        end
    endtask

    task automatic test_reset_mid();
        tick = 1; step(); step(); tick = 0;
        #2 sys.n_reset = 1'b0;
        #1;
        n_checks++;
        if ({smp.out_valid, rom_en, busy} !== 3'b000 || ovr_count !== 8'd0) begin
            n_errors++;
            $display("FAIL rstmid_async: valid/en/busy=%b ovr=%0d want 000/0",
                     {smp.out_valid, rom_en, busy}, ovr_count);
        end
        model_reset();
        #3 sys.n_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (smp.out_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL rstmid_quiet[%0d]: valid=%b busy=%b want 0/0",
                         i, smp.out_valid, busy);
            end
        end
    endtask

    task automatic test_ovr_clr();
        smp.out_ready = 1'b0;
        tick = 1; step(); tick = 0;
        step(); step(); step();
        tick = 1; step();
        step();
        n_checks++;
        if (ovr_count !== 8'd1) begin
            n_errors++;
            $display("FAIL clr_pre: ovr=%0d want 1", ovr_count);
        end
        ovr_clr = 1; step(); ovr_clr = 0;
        n_checks++;
        if (ovr_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_same_edge: ovr=%0d want 0", ovr_count);
        end
        for (int i = 0; i < 300; i++) step();
        n_checks++;
        if (ovr_count !== 8'd255) begin
            n_errors++;
            $display("FAIL ovr_saturate: ovr=%0d want 255", ovr_count);
        end
        tick = 0; ovr_clr = 1; step(); ovr_clr = 0;
        n_checks++;
        if (ovr_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_alone: ovr=%0d want 0", ovr_count);
        end
        smp.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (busy !== 1'b0 || smp.out_sample !== m_out) begin
            n_errors++;
            $display("FAIL clr_drain: busy=%b sample=%h want 0/%h", busy, smp.out_sample, m_out);
        end
    endtask

    task automatic test_random();
        fill_rom(2);
        for (int i = 0; i < 2000; i++) begin
            tick = ($urandom_range(0, 9) < 3);
            smp.out_ready = ($urandom_range(0, 9) < 6);
            ovr_clr = ($urandom_range(0, 99) < 3);
            set_in($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 127));
            step();
            n_checks++;
            if (smp.out_valid !== (m_age == 4) || busy !== (m_age != 0)
                || rom_en !== (m_age == 1 || m_age == 2)) begin
                n_errors++;
                $display("FAIL rnd_ctl[%0d]: valid=%b busy=%b en=%b age=%0d",
                         i, smp.out_valid, busy, rom_en, m_age);
            end
            n_checks++;
            if (smp.out_sample !== m_out || rom_addr !== 8'(m_rom_addr)
                || ovr_count !== 8'(m_ovr)) begin
                n_errors++;
                $display("FAIL rnd_data[%0d]: sample=%h/%h addr=%0d/%0d ovr=%0d/%0d",
                         i, smp.out_sample, m_out, rom_addr, m_rom_addr, ovr_count, m_ovr);
            end
        end
        tick = 0; ovr_clr = 0; smp.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_backpressure();
        test_overload();
        test_reset_mid();
        test_ovr_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
